seq_to_bcd: RTL and testbench

Sequential, parametrised binary-to-BCD converter using iterative double-dabble. It converts one bit per clock and exposes a start/busy/done handshake, so wide inputs and many digits cost a small, fixed amount of logic instead of a deep combinational chain. It sits between the reaction-game timing counters and the seven-segment digit drivers. Beyond the fixed 20-bit/6-digit combinational converter, it adds an overflow flag and a leading-zero blanking mask.

---
 rtl/seq_to_bcd_if.sv | 23 ++
 rtl/seq_to_bcd.sv | 133 +++++++++++++
 tb/tb_seq_to_bcd.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_to_bcd_if.sv
// Handshake and result bus for the sequential binary-to-BCD converter.
interface seq_to_bcd_if #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned DIGITS = 6
);
  logic                  start;
  logic [WIDTH-1:0]      number;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, number,
    input  busy, done, bcd, overflow, blank
  );

  modport slave (
    input  start, number,
    output busy, done, bcd, overflow, blank
  );
endinterface

// File: rtl/seq_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// start/busy/done handshake, sticky overflow and leading-zero blanking mask.
module seq_to_bcd #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic       i_clk,
  input  logic       i_reset,
  seq_to_bcd_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_load;
  logic                w_last;

  logic [WIDTH-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_digits;
  logic                r_ovf;
  logic [CW-1:0]       r_cnt;

  logic [4*DIGITS-1:0] r_bcd;
  logic                r_overflow;
  logic [DIGITS-1:0]   r_blank;
  logic                r_done;

  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_shifted;
  logic                w_out_bit;
  logic [DIGITS-1:0]   w_blank;

  // Add-3 correction applied to every scratch digit in parallel.
  always_comb begin
    w_adj = r_digits;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_digits[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_digits[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_shifted = {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
  assign w_out_bit = w_adj[4*DIGITS-1];

  // Blanking mask from the post-shift digits; scanned from the top down.
  always_comb begin
    logic v_zero;
    w_blank = '0;
    v_zero  = 1'b1;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      v_zero     = v_zero & (w_shifted[4*k +: 4] == 4'd0);
      w_blank[k] = v_zero;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic with load and final-step strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == CW'(1)) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture, shift/correct each SHIFT cycle, publish on the last step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift    <= '0;
      r_digits   <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_blank    <= BLANK_RST;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_shift  <= bus.number;
        r_digits <= '0;
        r_ovf    <= 1'b0;
        r_cnt    <= CW'(WIDTH);
      end else if (r_state == SHIFT) begin
        r_shift  <= r_shift << 1;
        r_digits <= w_shifted;
        r_ovf    <= r_ovf | w_out_bit;
        r_cnt    <= r_cnt - CW'(1);
        if (w_last) begin
          r_bcd      <= w_shifted;
          r_overflow <= r_ovf | w_out_bit;
          r_blank    <= w_blank;
        end
      end
    end
  end

  assign bus.busy     = (r_state == SHIFT);
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_overflow;
  assign bus.blank    = r_blank;

endmodule

// File: tb/tb_seq_to_bcd.sv
// Self-checking bench for seq_to_bcd: directed cases plus random values on the
// default 20-bit/6-digit instance, and a back-to-back sweep on an 8-bit/2-digit one.
module tb_seq_to_bcd;

  logic clk;
  logic reset;

  seq_to_bcd_if #(.WIDTH(20), .DIGITS(6)) bus20 ();
  seq_to_bcd_if #(.WIDTH(8),  .DIGITS(2)) bus8 ();

  seq_to_bcd #(.WIDTH(20), .DIGITS(6)) dut20 (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus20.slave)
  );

  seq_to_bcd #(.WIDTH(8), .DIGITS(2)) dut8 (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal arithmetic on the integer value.
  function automatic void model(input longint unsigned v, input int d,
                                output logic [39:0] b, output logic o,
                                output logic [9:0] bl);
    longint unsigned lim = 1;
    longint unsigned r;
    logic z;
    for (int i = 0; i < d; i++) lim = lim * 10;
    o = (v >= lim);
    r = v % lim;
    b = '0;
    for (int i = 0; i < d; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    bl = '0;
    z  = 1'b1;
    for (int i = d - 1; i >= 1; i--) begin
      z     = z && (b[4*i +: 4] == 4'd0);
      bl[i] = z;
    end
  endfunction

  // Starts a conversion at the current (negedge) time and waits for done.
  // glitch_at > 0 pulses start (number=123) during that busy cycle.
  task automatic conv20(input logic [19:0] n, input int glitch_at,
                        output int lat, output int busyc);
    int k;
    bus20.start  = 1'b1;
    bus20.number = n;
    @(negedge clk);
    bus20.start  = 1'b0;
    bus20.number = 20'($urandom);
    k = 1; lat = 0; busyc = 0;
    while (k < 60) begin
      if (bus20.busy) busyc++;
      if (bus20.done) begin
        lat = k;
        break;
      end
      if (k == glitch_at) begin
        bus20.start  = 1'b1;
        bus20.number = 20'd123;
      end else begin
        bus20.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check20(input string tag, input logic [19:0] n, input int lat, input int busyc);
    logic [39:0] eb; logic eo; logic [9:0] ebl;
    model(longint'(n), 6, eb, eo, ebl);
    check({tag, "_latency"}, 64'(lat), 64'd21);
    check({tag, "_busy_cycles"}, 64'(busyc), 64'd20);
    check({tag, "_bcd"}, 64'(bus20.bcd), 64'(eb[23:0]));
    check({tag, "_overflow"}, 64'(bus20.overflow), 64'(eo));
    check({tag, "_blank"}, 64'(bus20.blank), 64'(ebl[5:0]));
  endtask

  task automatic check_reset20(input string tag);
    check({tag, "_busy"}, 64'(bus20.busy), 64'd0);
    check({tag, "_done"}, 64'(bus20.done), 64'd0);
    check({tag, "_bcd"}, 64'(bus20.bcd), 64'h0);
    check({tag, "_overflow"}, 64'(bus20.overflow), 64'd0);
    check({tag, "_blank"}, 64'(bus20.blank), 64'b111110);
  endtask

  initial begin
    int lat, busyc, k, seen_done;
    logic [19:0] rn;
    logic [39:0] eb; logic eo; logic [9:0] ebl;

    reset = 1'b1;
    bus20.start = 1'b0; bus20.number = '0;
    bus8.start  = 1'b0; bus8.number  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_reset20("reset");
    check("reset8_blank", 64'(bus8.blank), 64'b10);

    // Directed values including the overflow boundaries.
    conv20(20'd999999, 0, lat, busyc);
    check20("v999999", 20'd999999, lat, busyc);
    check("v999999_blank_abs", 64'(bus20.blank), 64'b000000);
    @(negedge clk);
    check("done_single_cycle", 64'(bus20.done), 64'd0);

    conv20(20'd1048575, 0, lat, busyc);
    check20("v1048575", 20'd1048575, lat, busyc);
    check("v1048575_abs", {bus20.overflow, bus20.blank, bus20.bcd}, {1'b1, 6'b100000, 24'h048575});
    @(negedge clk);

    conv20(20'd1000000, 0, lat, busyc);
    check20("v1000000", 20'd1000000, lat, busyc);
    @(negedge clk);

    conv20(20'd42, 0, lat, busyc);
    check20("v42", 20'd42, lat, busyc);
    check("v42_abs", {bus20.blank, bus20.bcd}, {6'b111100, 24'h000042});
    @(negedge clk);

    // Start while busy must be ignored; then start in the done cycle.
    conv20(20'd7, 5, lat, busyc);
    check20("v7_glitch", 20'd7, lat, busyc);
    conv20(20'd0, 0, lat, busyc);
    check20("v0_back2back", 20'd0, lat, busyc);
    @(negedge clk);

    // Reset in cycle 7 of a conversion aborts it.
    bus20.start  = 1'b1;
    bus20.number = 20'd654321;
    @(negedge clk);
    bus20.start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset20("midreset");
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus20.done) seen_done = 1;
    end
    check("midreset_no_done", 64'(seen_done), 64'd0);

    // Random values.
    for (int i = 0; i < 20; i++) begin
      rn = 20'($urandom);
      conv20(rn, 0, lat, busyc);
      check20("rand", rn, lat, busyc);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    // 8-bit/2-digit sweep, each start issued in the previous done cycle.
    for (int v = 0; v < 256; v++) begin
      bus8.start  = 1'b1;
      bus8.number = 8'(v);
      @(negedge clk);
      bus8.start  = 1'b0;
      bus8.number = 8'($urandom);
      k = 1; lat = 0;
      while (k < 30) begin
        if (bus8.done) begin
          lat = k;
          break;
        end
        @(negedge clk);
        k++;
      end
      model(longint'(v), 2, eb, eo, ebl);
      check("sweep_spacing", 64'(lat), 64'd9);
      check("sweep_bcd", 64'(bus8.bcd), 64'(eb[7:0]));
      check("sweep_overflow", 64'(bus8.overflow), 64'(v >= 100));
      check("sweep_blank", 64'(bus8.blank), 64'(ebl[1:0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
